// File: rtl/ceespu_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ceespu_wb_arbiter                                                      |
// | Round-robin ALU/LSU writeback arbiter for the register-file write port |
// | with a per-register pending-write scoreboard for RAW hazard detection. |
// | Optional: CEESPU_WB_FORWARD_EN adds write-port forwarding outputs.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ceespu_wb_arbiter #(
  parameter  int DATA_W      = 32,
  parameter  int NUM_REGS    = 32,
  parameter  int R0_WRITABLE = 1,
  localparam int SEL_W       = $clog2(NUM_REGS)
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_alu_valid,
  input  logic [SEL_W-1:0]  I_alu_sel,
  input  logic [DATA_W-1:0] I_alu_data,
  output logic              O_alu_ready,
  input  logic              I_lsu_valid,
  input  logic [SEL_W-1:0]  I_lsu_sel,
  input  logic [DATA_W-1:0] I_lsu_data,
  output logic              O_lsu_ready,
  input  logic              I_iss_valid,
  input  logic [SEL_W-1:0]  I_iss_sel,
  output logic              O_iss_ready,
  input  logic [SEL_W-1:0]  I_selA,
  input  logic [SEL_W-1:0]  I_selB,
  output logic              O_hazA,
  output logic              O_hazB,
`ifdef CEESPU_WB_FORWARD_EN
  output logic              O_fwdA,
  output logic              O_fwdB,
  output logic [DATA_W-1:0] O_fwd_data,
`endif
  output logic              O_we,
  output logic [SEL_W-1:0]  O_selD,
  output logic [DATA_W-1:0] O_dataD
);

  localparam logic [1:0] C_CNT_MAX = 2'd3;

  logic              r_rrLsu;   // 1: LSU wins the next contended cycle
  logic              r_we;
  logic [SEL_W-1:0]  r_selD;
  logic [DATA_W-1:0] r_dataD;
  logic [1:0]        r_cnt [NUM_REGS];

  logic              w_contend;
  logic              w_gntAlu;
  logic              w_gntLsu;
  logic [SEL_W-1:0]  w_gntSel;
  logic [DATA_W-1:0] w_gntData;
  logic              w_wrEn;
  logic              w_issMark;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic              w_hazA;
  logic              w_hazB;

  assign w_contend   = I_alu_valid & I_lsu_valid;
  assign w_gntAlu    = I_alu_valid & (~I_lsu_valid | ~r_rrLsu);
  assign w_gntLsu    = I_lsu_valid & (~I_alu_valid | r_rrLsu);
  assign O_alu_ready = w_gntAlu;
  assign O_lsu_ready = w_gntLsu;

  always_comb begin
    w_gntSel  = I_alu_sel;
    w_gntData = I_alu_data;
    if (w_gntLsu) begin
      w_gntSel  = I_lsu_sel;
      w_gntData = I_lsu_data;
    end
  end

  // r0 writes are still accepted when read-only, they just never reach the port
  assign w_wrEn = (w_gntAlu | w_gntLsu) & ((R0_WRITABLE != 0) || (w_gntSel != '0));

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_rrLsu <= 1'b0;
      r_we    <= 1'b0;
      r_selD  <= '0;
      r_dataD <= '0;
    end else begin
      r_we <= w_wrEn;
      if (w_wrEn) begin
        r_selD  <= w_gntSel;
        r_dataD <= w_gntData;
      end
      if (w_contend) begin
        r_rrLsu <= ~r_rrLsu;
      end
    end
  end

  assign O_we    = r_we;
  assign O_selD  = r_selD;
  assign O_dataD = r_dataD;

  assign O_iss_ready = (r_cnt[I_iss_sel] != C_CNT_MAX);
  assign w_issMark   = I_iss_valid & O_iss_ready & ((R0_WRITABLE != 0) || (I_iss_sel != '0));

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issMark) begin
      w_inc[I_iss_sel] = 1'b1;
    end
    if (r_we) begin
      w_dec[r_selD] = 1'b1;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i] && r_cnt[i] != C_CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + 2'd1;
        end else if (w_dec[i] && !w_inc[i] && r_cnt[i] != 2'd0) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge I_clk) begin
    if (!I_rst && r_we && r_cnt[r_selD] == 2'd0 && !w_inc[r_selD]) begin
      $display("ceespu_wb_arbiter: warning: writeback to r%0d with no pending issue", r_selD);
    end
  end
`endif

  assign w_hazA = (r_cnt[I_selA] != 2'd0);
  assign w_hazB = (r_cnt[I_selB] != 2'd0);

`ifdef CEESPU_WB_FORWARD_EN
  // last outstanding write is on the port now: consumer takes the forwarded value
  assign O_fwdA     = r_we & (r_selD == I_selA);
  assign O_fwdB     = r_we & (r_selD == I_selB);
  assign O_fwd_data = r_dataD;
  assign O_hazA     = w_hazA & ~(O_fwdA & (r_cnt[I_selA] == 2'd1));
  assign O_hazB     = w_hazB & ~(O_fwdB & (r_cnt[I_selB] == 2'd1));
`else
  assign O_hazA = w_hazA;
  assign O_hazB = w_hazB;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ceespu_wb_arbiter.sv
`default_nettype none
// Bench for ceespu_wb_arbiter: directed stimulus, behavioural model checked
// every cycle, plus literal expectations; second instance has r0 read-only.
module tb_ceespu_wb_arbiter;

`ifdef CEESPU_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic I_clk = 1'b0;
  always #5 I_clk = ~I_clk;
  logic I_rst;

  logic        aluValid, lsuValid, issValid;
  logic [4:0]  aluSel, lsuSel, issSel, selA, selB;
  logic [31:0] aluData, lsuData;
  logic        aluReady, lsuReady, issReady, hazA, hazB, we;
  logic [4:0]  selD;
  logic [31:0] dataD;

  logic        zLsuValid, zIssValid;
  logic [4:0]  zLsuSel, zIssSel, zSelA;
  logic [31:0] zLsuData;
  logic        zAluReady, zLsuReady, zIssReady, zHazA, zHazB, zWe;
  logic [4:0]  zSelD;
  logic [31:0] zDataD;

`ifdef CEESPU_WB_FORWARD_EN
  logic        fwdA, fwdB, zFwdA, zFwdB;
  logic [31:0] fwdData, zFwdData;
`endif

  ceespu_wb_arbiter #(.DATA_W(32), .NUM_REGS(32), .R0_WRITABLE(1)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_alu_valid(aluValid), .I_alu_sel(aluSel), .I_alu_data(aluData), .O_alu_ready(aluReady),
    .I_lsu_valid(lsuValid), .I_lsu_sel(lsuSel), .I_lsu_data(lsuData), .O_lsu_ready(lsuReady),
    .I_iss_valid(issValid), .I_iss_sel(issSel), .O_iss_ready(issReady),
    .I_selA(selA), .I_selB(selB), .O_hazA(hazA), .O_hazB(hazB),
`ifdef CEESPU_WB_FORWARD_EN
    .O_fwdA(fwdA), .O_fwdB(fwdB), .O_fwd_data(fwdData),
`endif
    .O_we(we), .O_selD(selD), .O_dataD(dataD)
  );

  ceespu_wb_arbiter #(.DATA_W(32), .NUM_REGS(32), .R0_WRITABLE(0)) dut0 (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_alu_valid(1'b0), .I_alu_sel(5'd0), .I_alu_data(32'd0), .O_alu_ready(zAluReady),
    .I_lsu_valid(zLsuValid), .I_lsu_sel(zLsuSel), .I_lsu_data(zLsuData), .O_lsu_ready(zLsuReady),
    .I_iss_valid(zIssValid), .I_iss_sel(zIssSel), .O_iss_ready(zIssReady),
    .I_selA(zSelA), .I_selB(5'd0), .O_hazA(zHazA), .O_hazB(zHazB),
`ifdef CEESPU_WB_FORWARD_EN
    .O_fwdA(zFwdA), .O_fwdB(zFwdB), .O_fwd_data(zFwdData),
`endif
    .O_we(zWe), .O_selD(zSelD), .O_dataD(zDataD)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending writes per register, one-deep write slot
  int          mCnt [32];
  bit          mPrefLsu = 1'b0;
  bit          mWe = 1'b0;
  int          mSel = 0;
  logic [31:0] mData = 32'd0;
  bit          mGA, mGL;
  int          mInc, mDec;
  bit          chkEn = 1'b0;

  initial for (int i = 0; i < 32; i++) mCnt[i] = 0;

  always @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
      mPrefLsu = 1'b0;
      mWe = 1'b0;
      mSel = 0;
      mData = 32'd0;
    end else begin
      mGA  = aluValid && (!lsuValid || !mPrefLsu);
      mGL  = lsuValid && (!aluValid || mPrefLsu);
      mDec = mWe ? mSel : -1;
      mInc = (issValid && mCnt[issSel] < 3) ? int'(issSel) : -1;
      if (mInc >= 0) mCnt[mInc] = mCnt[mInc] + 1;
      if (mDec >= 0 && mCnt[mDec] > 0) mCnt[mDec] = mCnt[mDec] - 1;
      mWe = mGA || mGL;
      if (mGA) begin mSel = aluSel; mData = aluData; end
      if (mGL) begin mSel = lsuSel; mData = lsuData; end
      if (aluValid && lsuValid) mPrefLsu = !mPrefLsu;
    end
  end

  function automatic bit expHaz(input logic [4:0] s);
    bit h;
    h = (mCnt[s] != 0);
    if (FWD && mWe && mSel == int'(s) && mCnt[s] == 1) h = 1'b0;
    return h;
  endfunction

  always @(negedge I_clk) begin
    if (chkEn && !I_rst) begin
      chk("m_aluReady", aluReady, aluValid && (!lsuValid || !mPrefLsu));
      chk("m_lsuReady", lsuReady, lsuValid && (!aluValid || mPrefLsu));
      chk("m_issReady", issReady, mCnt[issSel] != 3);
      chk("m_we", we, mWe);
      chk("m_selD", selD, mSel);
      chk("m_dataD", dataD, mData);
      chk("m_hazA", hazA, expHaz(selA));
      chk("m_hazB", hazB, expHaz(selB));
`ifdef CEESPU_WB_FORWARD_EN
      chk("m_fwdA", fwdA, mWe && mSel == int'(selA));
      chk("m_fwdB", fwdB, mWe && mSel == int'(selB));
      chk("m_fwdData", fwdData, mData);
`endif
    end
  end

  task automatic nextCyc();
    @(posedge I_clk); #1;
  endtask

  task automatic midCyc();
    @(negedge I_clk); #1;
  endtask

  initial begin
    aluValid = 0; lsuValid = 0; issValid = 0;
    aluSel = 0; lsuSel = 0; issSel = 0; selA = 0; selB = 0;
    aluData = 0; lsuData = 0;
    zLsuValid = 0; zIssValid = 0; zLsuSel = 0; zIssSel = 0; zSelA = 0; zLsuData = 0;
    I_rst = 1'b1;
    repeat (3) @(posedge I_clk);
    #1 I_rst = 1'b0;
    chkEn = 1'b1;

    midCyc();
    chk("rst_we", we, 0);
    chk("rst_selD", selD, 0);
    chk("rst_dataD", dataD, 0);
    chk("rst_hazA", hazA, 0);
    chk("rst_issReady", issReady, 1);
    chk("rst_zWe", zWe, 0);

    // reset aborts a registered write
    nextCyc();
    aluValid = 1; aluSel = 3; aluData = 32'h11; issValid = 1; issSel = 3; selA = 3;
    midCyc();
    chk("rmw_aluReady", aluReady, 1);
    nextCyc();
    aluValid = 0; issValid = 0;
    midCyc();
    chk("rmw_we", we, 1);
    chk("rmw_selD", selD, 3);
    chk("rmw_hazA", hazA, FWD ? 0 : 1);
    #1 I_rst = 1'b1;
    #1;
    chk("rmw_we_after", we, 0);
    chk("rmw_selD_after", selD, 0);
    chk("rmw_dataD_after", dataD, 0);
    chk("rmw_hazA_after", hazA, 0);
    nextCyc();
    I_rst = 1'b0;

    // single source
    selA = 5; aluValid = 1; aluSel = 5; aluData = 32'hDEADBEEF; issValid = 1; issSel = 5;
    midCyc();
    chk("single_aluReady", aluReady, 1);
    chk("single_lsuReady", lsuReady, 0);
    nextCyc();
    aluValid = 0; issValid = 0;
    midCyc();
    chk("single_we", we, 1);
    chk("single_selD", selD, 5);
    chk("single_dataD", dataD, 32'hDEADBEEF);
    nextCyc();

    // contention: pre-issue r1 x2, r2 x2, then alternate grants
    for (int i = 0; i < 4; i++) begin
      issValid = 1; issSel = (i < 2) ? 5'd1 : 5'd2;
      nextCyc();
    end
    issValid = 0;
    selA = 1; selB = 2;
    aluValid = 1; aluSel = 1; aluData = 32'd1;
    lsuValid = 1; lsuSel = 2; lsuData = 32'd2;
    for (int k = 0; k < 5; k++) begin
      midCyc();
      if (k < 4) begin
        chk("rr_aluReady", aluReady, (k % 2) == 0);
        chk("rr_lsuReady", lsuReady, (k % 2) == 1);
      end
      if (k > 0) chk("rr_selD", selD, ((k - 1) % 2 == 0) ? 1 : 2);
      nextCyc();
      if (k == 3) begin aluValid = 0; lsuValid = 0; end
    end

    // scoreboard saturation and drain of r7
    selA = 7; issSel = 7; issValid = 1;
    repeat (3) nextCyc();
    issValid = 0;
    midCyc();
    chk("sb_issReady_sat", issReady, 0);
    chk("sb_hazA_sat", hazA, 1);
    nextCyc();
    for (int k = 0; k < 4; k++) begin
      aluValid = 1; aluSel = 7; aluData = 32'hA0 + k;
      issValid = (k == 2);
      if (k == 2) begin
        midCyc();
        chk("sb_issReady_mid", issReady, 1);
      end
      nextCyc();
    end
    aluValid = 0; issValid = 0;
    midCyc();
    chk("sb_we_last", we, 1);
    chk("sb_dataD_last", dataD, 32'hA3);
    chk("sb_hazA_last", hazA, FWD ? 0 : 1);
    nextCyc();
    midCyc();
    chk("sb_hazA_clear", hazA, 0);
    chk("sb_we_idle", we, 0);
    nextCyc();

    // single pending write to r9, observed in its write cycle
    issValid = 1; issSel = 9;
    nextCyc();
    issValid = 0; aluValid = 1; aluSel = 9; aluData = 32'h1234;
    nextCyc();
    aluValid = 0; selA = 9;
    midCyc();
    chk("fw_we", we, 1);
`ifdef CEESPU_WB_FORWARD_EN
    chk("fw_fwdA", fwdA, 1);
    chk("fw_fwdData", fwdData, 32'h1234);
    chk("fw_hazA", hazA, 0);
`else
    chk("fw_hazA", hazA, 1);
`endif
    nextCyc();

    // read-only r0 instance
    zLsuValid = 1; zLsuSel = 0; zLsuData = 32'h55; zIssValid = 1; zIssSel = 0; zSelA = 0;
    midCyc();
    chk("r0_lsuReady", zLsuReady, 1);
    chk("r0_issReady", zIssReady, 1);
    nextCyc();
    zLsuValid = 0; zIssValid = 0;
    midCyc();
    chk("r0_we", zWe, 0);
    chk("r0_hazA", zHazA, 0);
    nextCyc();
    midCyc();
    chk("r0_we2", zWe, 0);
    chk("r0_hazA2", zHazA, 0);

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
